// File: rtl/mont_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// mont_cmd_ctrl
//   Command controller between the Arm host and an external Montgomery core.
//   Decodes 32-bit commands, loads operands A/B/M from the wide inbound bus,
//   starts the core with a single-cycle pulse, bounds each run with a
//   watchdog, returns the result on the outbound bus, and reports status.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   arm_to_fpga_cmd[_valid]     command word and strobe (taken in IDLE only)
//   fpga_to_arm_done[_read]     completion flag, held until acknowledged
//   fpga_to_arm_status          0 OK, 1 BAD_CMD, 2 NO_MOD, 3 TIMEOUT
//   arm_to_fpga_data*           inbound valid/ready/data ({A or M, B})
//   fpga_to_arm_data*           outbound valid/ready/data ({zeros, result})
//   core_resetn, core_start     core control (registered)
//   core_a, core_b, core_m      operand registers
//   core_result, core_done      core result and completion
//   leds                        {m_loaded, state}
// ---------------------------------------------------------------------------
module mont_cmd_ctrl #(
  parameter int TX_SIZE      = 1024,
  parameter int OP_WIDTH     = 512,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         arm_to_fpga_cmd,
  input  logic                arm_to_fpga_cmd_valid,
  output logic                fpga_to_arm_done,
  input  logic                fpga_to_arm_done_read,
  output logic [1:0]          fpga_to_arm_status,
  input  logic                arm_to_fpga_data_valid,
  output logic                arm_to_fpga_data_ready,
  input  logic [TX_SIZE-1:0]  arm_to_fpga_data,
  output logic                fpga_to_arm_data_valid,
  input  logic                fpga_to_arm_data_ready,
  output logic [TX_SIZE-1:0]  fpga_to_arm_data,
  output logic                core_resetn,
  output logic                core_start,
  output logic [OP_WIDTH-1:0] core_a,
  output logic [OP_WIDTH-1:0] core_b,
  output logic [OP_WIDTH-1:0] core_m,
  input  logic [OP_WIDTH-1:0] core_result,
  input  logic                core_done,
  output logic [3:0]          leds
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_WRITE = 3'd4,
    S_CLR   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] CMD_LOAD_AB  = 4'h1;
  localparam logic [3:0] CMD_LOAD_M   = 4'h2;
  localparam logic [3:0] CMD_COMPUTE  = 4'h4;
  localparam logic [3:0] CMD_READ_RES = 4'h8;
  localparam logic [3:0] CMD_SOFT_RST = 4'h9;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_CMD = 2'd1;
  localparam logic [1:0] ST_NO_MOD  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  // The counter is cleared in START and advances once per BUSY cycle; the
  // run is abandoned on the cycle it would step onto all-ones, so BUSY
  // lasts at most 2**TIMEOUT_BITS-1 cycles.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_t                  state, next_state;
  logic [3:0]              cmd_reg;
  logic                    m_loaded;
  logic [OP_WIDTH-1:0]     result;
  logic [TIMEOUT_BITS-1:0] wdog;
  logic [1:0]              status;

  logic is_load_ab, is_load_m, is_compute, is_read, is_soft;
  logic in_hs, out_hs, done_hs, wd_expired;

  logic start_d, core_resetn_d, ready_d, out_valid_d, done_d;

  assign is_load_ab = (arm_to_fpga_cmd == {28'd0, CMD_LOAD_AB});
  assign is_load_m  = (arm_to_fpga_cmd == {28'd0, CMD_LOAD_M});
  assign is_compute = (arm_to_fpga_cmd == {28'd0, CMD_COMPUTE});
  assign is_read    = (arm_to_fpga_cmd == {28'd0, CMD_READ_RES});
  assign is_soft    = (arm_to_fpga_cmd == {28'd0, CMD_SOFT_RST});

  assign in_hs      = arm_to_fpga_data_valid && arm_to_fpga_data_ready;
  assign out_hs     = fpga_to_arm_data_valid && fpga_to_arm_data_ready;
  assign done_hs    = fpga_to_arm_done && fpga_to_arm_done_read;
  assign wd_expired = (wdog == WD_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          if (is_load_ab || is_load_m) next_state = S_LOAD;
          else if (is_compute)         next_state = m_loaded ? S_START : S_DONE;
          else if (is_read)            next_state = S_WRITE;
          else if (is_soft)            next_state = S_CLR;
          else                         next_state = S_DONE;
        end
      end
      S_LOAD:  if (in_hs) next_state = S_DONE;
      S_START: next_state = S_BUSY;
      // core_done wins over an expiring watchdog in the same cycle
      S_BUSY: begin
        if (core_done)       next_state = S_DONE;
        else if (wd_expired) next_state = S_CLR;
      end
      S_WRITE: if (out_hs) next_state = S_DONE;
      S_CLR:   next_state = S_DONE;
      S_DONE:  if (done_hs) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake outputs drop as soon as their transfer completes so that a
  // registered, one-cycle-late output never offers a second beat.
  always_comb begin
    start_d       = (state == S_START);
    core_resetn_d = (state != S_CLR);
    ready_d       = (state == S_LOAD)  && !in_hs;
    out_valid_d   = (state == S_WRITE) && !out_hs;
    done_d        = (state == S_DONE)  && !done_hs;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_start             <= 1'b0;
      core_resetn            <= 1'b0;
      arm_to_fpga_data_ready <= 1'b0;
      fpga_to_arm_data_valid <= 1'b0;
      fpga_to_arm_done       <= 1'b0;
    end else begin
      core_start             <= start_d;
      core_resetn            <= core_resetn_d;
      arm_to_fpga_data_ready <= ready_d;
      fpga_to_arm_data_valid <= out_valid_d;
      fpga_to_arm_done       <= done_d;
    end
  end

  // Status is written only on the way into DONE (or into CLR for a
  // timeout), so it is already settled by the time done rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_reg  <= 4'd0;
      m_loaded <= 1'b0;
      core_a   <= '0;
      core_b   <= '0;
      core_m   <= '0;
      result   <= '0;
      wdog     <= '0;
      status   <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            cmd_reg <= arm_to_fpga_cmd[3:0];
            if (!(is_load_ab || is_load_m || is_compute || is_read || is_soft))
              status <= ST_BAD_CMD;
            else if (is_compute && !m_loaded)
              status <= ST_NO_MOD;
          end
        end
        S_LOAD: begin
          if (in_hs) begin
            if (cmd_reg == CMD_LOAD_M) begin
              core_m   <= arm_to_fpga_data[TX_SIZE-1:OP_WIDTH];
              m_loaded <= 1'b1;
            end else begin
              core_a <= arm_to_fpga_data[TX_SIZE-1:OP_WIDTH];
              core_b <= arm_to_fpga_data[OP_WIDTH-1:0];
            end
            status <= ST_OK;
          end
        end
        S_START: wdog <= '0;
        S_BUSY: begin
          if (core_done) begin
            result <= core_result;
            status <= ST_OK;
          end else begin
            wdog <= wdog + 1'b1;
            if (wd_expired) status <= ST_TIMEOUT;
          end
        end
        S_WRITE: if (out_hs) status <= ST_OK;
        // CLR is shared by SOFT_RST and the timeout abort; only the former
        // wipes the operand and result registers.
        S_CLR: begin
          if (cmd_reg == CMD_SOFT_RST) begin
            m_loaded <= 1'b0;
            core_a   <= '0;
            core_b   <= '0;
            core_m   <= '0;
            result   <= '0;
            status   <= ST_OK;
          end
        end
        default: ;
      endcase
    end
  end

  assign fpga_to_arm_status = status;
  assign fpga_to_arm_data   = {{(TX_SIZE-OP_WIDTH){1'b0}}, result};
  assign leds               = {m_loaded, state};

endmodule

// File: tb/tb_mont_cmd_ctrl.sv
// Testbench for mont_cmd_ctrl with a narrow configuration (16-bit bus,
// 8-bit operands, 4-bit watchdog) and a behavioural core stub.
module tb_mont_cmd_ctrl;

  localparam int TXW = 16;
  localparam int OPW = 8;
  localparam int TOB = 4;

  localparam logic [31:0] C_LOAD_AB = 32'h1;
  localparam logic [31:0] C_LOAD_M  = 32'h2;
  localparam logic [31:0] C_COMPUTE = 32'h4;
  localparam logic [31:0] C_READ    = 32'h8;
  localparam logic [31:0] C_SOFT    = 32'h9;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [31:0]    cmd = '0;
  logic           cmd_valid = 1'b0;
  logic           done;
  logic           done_read = 1'b0;
  logic [1:0]     status;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [TXW-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [TXW-1:0] out_data;
  logic           core_resetn, core_start;
  logic [OPW-1:0] core_a, core_b, core_m;
  logic [OPW-1:0] core_result = '0;
  logic           core_done;
  logic [3:0]     leds;

  int total = 0;
  int bad = 0;

  logic [1:0]     exp_status_q[$];
  logic [TXW-1:0] exp_data_q[$];

  int stub_delay = 0;
  int stub_cnt;
  logic stub_run;

  int cyc = 0, start_cyc = 0, cmd_cyc = 0;
  int start_count = 0, rst_low_count = 0, busy_count = 0;

  mont_cmd_ctrl #(.TX_SIZE(TXW), .OP_WIDTH(OPW), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .resetn(resetn),
    .arm_to_fpga_cmd(cmd), .arm_to_fpga_cmd_valid(cmd_valid),
    .fpga_to_arm_done(done), .fpga_to_arm_done_read(done_read),
    .fpga_to_arm_status(status),
    .arm_to_fpga_data_valid(in_valid), .arm_to_fpga_data_ready(in_ready),
    .arm_to_fpga_data(in_data),
    .fpga_to_arm_data_valid(out_valid), .fpga_to_arm_data_ready(out_ready),
    .fpga_to_arm_data(out_data),
    .core_resetn(core_resetn), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_m(core_m),
    .core_result(core_result), .core_done(core_done), .leds(leds)
  );

  always #5 clk = ~clk;

  // Core stub: pulses core_done stub_delay cycles after start (0 = never).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (!core_resetn) stub_run <= 1'b0;
      else if (core_start) begin
        stub_run <= (stub_delay != 0);
        stub_cnt <= 1;
      end else if (stub_run) begin
        stub_cnt <= stub_cnt + 1;
        if (stub_cnt == stub_delay) begin
          core_done <= 1'b1;
          stub_run  <= 1'b0;
        end
      end
    end
  end

  // Event monitors used for pulse counts and latencies.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start) begin
      start_count <= start_count + 1;
      start_cyc   <= cyc;
    end
    if (resetn && !core_resetn) rst_low_count <= rst_low_count + 1;
    if (leds[2:0] == 3'd3) busy_count <= busy_count + 1;
  end

  task automatic send_cmd(input logic [31:0] c);
    @(negedge clk);
    cmd = c; cmd_valid = 1'b1; cmd_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic seen, output logic [1:0] st,
                           output logic [1:0] exp);
    seen = 1'b0; st = 2'd0;
    exp = (exp_status_q.size() > 0) ? exp_status_q.pop_front() : 2'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; st = status; break; end
    end
    if (seen) begin
      done_read = 1'b1;
      @(negedge clk);
      done_read = 1'b0;
    end
  endtask

  task automatic load_op(input logic [31:0] c, input logic [TXW-1:0] d, output logic ok);
    send_cmd(c);
    in_data = d; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read_result(output logic seen, output logic [TXW-1:0] got);
    send_cmd(C_READ);
    out_ready = 1'b1; seen = 1'b0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; got = out_data; break; end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got=%b want=0", done); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL rst_status: got=%0d want=0", status); end
    total++; if (core_resetn !== 1'b0) begin bad++; $display("[TB] FAIL rst_core_resetn: got=%b want=0", core_resetn); end
    total++; if (leds !== 4'd0) begin bad++; $display("[TB] FAIL rst_leds: got=%h want=0", leds); end
    total++; if ({core_start, in_ready, out_valid} !== 3'b000) begin bad++; $display("[TB] FAIL rst_ctrl: got=%b want=000", {core_start, in_ready, out_valid}); end
    total++; if (out_data !== '0 || core_m !== '0) begin bad++; $display("[TB] FAIL rst_regs: data=%h m=%h want=0", out_data, core_m); end
    resetn = 1'b1;
    #1;
    total++; if (core_resetn !== 1'b0) begin bad++; $display("[TB] FAIL rst_release_early: got=%b want=0", core_resetn); end
    @(negedge clk);
    total++; if (core_resetn !== 1'b1) begin bad++; $display("[TB] FAIL rst_release: got=%b want=1", core_resetn); end
  endtask

  task automatic test_no_modulus();
    logic seen; logic [1:0] st, exp; int base;
    base = start_count;
    exp_status_q.push_back(2'd2);
    send_cmd(C_COMPUTE);
    wait_done(50, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL nomod_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    total++; if (start_count - base !== 0) begin bad++; $display("[TB] FAIL nomod_start: got=%0d want=0", start_count - base); end
  endtask

  task automatic test_compute();
    logic seen, ok; logic [1:0] st, exp; logic [TXW-1:0] got, wd; int base;
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_M, {8'hF1, 8'h00}, ok);
    wait_done(50, seen, st, exp);
    total++; if (!ok || !seen || st !== exp) begin bad++; $display("[TB] FAIL load_m: ok=%b seen=%b got=%0d want=%0d", ok, seen, st, exp); end
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_AB, {8'd3, 8'd5}, ok);
    wait_done(50, seen, st, exp);
    total++; if (!ok || !seen || st !== exp) begin bad++; $display("[TB] FAIL load_ab: ok=%b seen=%b got=%0d want=%0d", ok, seen, st, exp); end
    total++; if ({core_a, core_b, core_m} !== {8'd3, 8'd5, 8'hF1}) begin bad++; $display("[TB] FAIL operands: got=%h want=0305f1", {core_a, core_b, core_m}); end
    total++; if (leds[3] !== 1'b1) begin bad++; $display("[TB] FAIL m_loaded_led: got=%b want=1", leds[3]); end
    stub_delay = 10; core_result = 8'h2A; base = start_count;
    exp_status_q.push_back(2'd0);
    send_cmd(C_COMPUTE);
    wait_done(100, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL compute_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    total++; if (start_count - base !== 1) begin bad++; $display("[TB] FAIL compute_starts: got=%0d want=1", start_count - base); end
    total++; if (start_cyc - cmd_cyc !== 2) begin bad++; $display("[TB] FAIL start_latency: got=%0d want=2", start_cyc - cmd_cyc); end
    exp_status_q.push_back(2'd0);
    exp_data_q.push_back(16'h002A);
    read_result(seen, got);
    wd = exp_data_q.pop_front();
    total++; if (!seen || got !== wd) begin bad++; $display("[TB] FAIL read_data: seen=%b got=%h want=%h", seen, got, wd); end
    wait_done(50, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL read_status: seen=%b got=%0d want=%0d", seen, st, exp); end
  endtask

  task automatic test_timeout();
    logic seen; logic [1:0] st, exp; int bb, rb;
    stub_delay = 0; bb = busy_count; rb = rst_low_count;
    exp_status_q.push_back(2'd3);
    send_cmd(C_COMPUTE);
    wait_done(100, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL timeout_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    total++; if (busy_count - bb !== 15) begin bad++; $display("[TB] FAIL timeout_busy_cycles: got=%0d want=15", busy_count - bb); end
    total++; if (rst_low_count - rb !== 1) begin bad++; $display("[TB] FAIL timeout_core_reset: got=%0d want=1", rst_low_count - rb); end
    total++; if (out_data !== 16'h002A) begin bad++; $display("[TB] FAIL timeout_result_kept: got=%h want=002a", out_data); end
  endtask

  task automatic test_bad_cmd_and_ignore();
    logic seen; logic [1:0] st, exp; int base;
    exp_status_q.push_back(2'd1);
    send_cmd(32'h7);
    wait_done(50, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL bad_cmd_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    stub_delay = 12; core_result = 8'h55; base = start_count;
    exp_status_q.push_back(2'd0);
    send_cmd(C_COMPUTE);
    repeat (3) @(negedge clk);
    total++; if (leds[2:0] !== 3'd3) begin bad++; $display("[TB] FAIL in_busy: got=%0d want=3", leds[2:0]); end
    cmd = C_SOFT; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(100, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL back_to_back_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    total++; if (leds[3] !== 1'b1 || out_data !== 16'h0055) begin bad++; $display("[TB] FAIL ignored_cmd: led3=%b data=%h want 1/0055", leds[3], out_data); end
    total++; if (start_count - base !== 1) begin bad++; $display("[TB] FAIL back_to_back_starts: got=%0d want=1", start_count - base); end
  endtask

  task automatic test_soft_reset();
    logic seen; logic [1:0] st, exp; int base;
    exp_status_q.push_back(2'd0);
    send_cmd(C_SOFT);
    wait_done(50, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL soft_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    total++; if (leds[3] !== 1'b0) begin bad++; $display("[TB] FAIL soft_m_loaded: got=%b want=0", leds[3]); end
    total++; if ({core_a, core_b, core_m} !== 24'd0 || out_data !== '0) begin bad++; $display("[TB] FAIL soft_clear: ops=%h data=%h want 0", {core_a, core_b, core_m}, out_data); end
    base = start_count;
    exp_status_q.push_back(2'd2);
    send_cmd(C_COMPUTE);
    wait_done(50, seen, st, exp);
    total++; if (!seen || st !== exp || start_count !== base) begin bad++; $display("[TB] FAIL soft_then_compute: seen=%b got=%0d want=%0d starts=%0d", seen, st, exp, start_count - base); end
  endtask

  task automatic test_async_reset();
    logic seen, ok; logic [1:0] st, exp; logic [TXW-1:0] got, wd;
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_M, {8'h0B, 8'h00}, ok);
    wait_done(50, seen, st, exp);
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_AB, {8'd4, 8'd6}, ok);
    wait_done(50, seen, st, exp);
    stub_delay = 30;
    exp_status_q.push_back(2'd0);
    send_cmd(C_COMPUTE);
    repeat (4) @(negedge clk);
    total++; if (leds[2:0] !== 3'd3) begin bad++; $display("[TB] FAIL arst_in_busy: got=%0d want=3", leds[2:0]); end
    #2 resetn = 1'b0;
    #1;
    total++; if ({done, core_start, core_resetn, leds} !== 7'd0) begin bad++; $display("[TB] FAIL arst_outputs: got=%b want=0", {done, core_start, core_resetn, leds}); end
    total++; if ({core_a, core_b, core_m} !== 24'd0) begin bad++; $display("[TB] FAIL arst_operands: got=%h want=0", {core_a, core_b, core_m}); end
    exp_status_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_M, {8'hC5, 8'h00}, ok);
    wait_done(50, seen, st, exp);
    exp_status_q.push_back(2'd0);
    load_op(C_LOAD_AB, {8'd7, 8'd9}, ok);
    wait_done(50, seen, st, exp);
    stub_delay = 5; core_result = 8'h77;
    exp_status_q.push_back(2'd0);
    send_cmd(C_COMPUTE);
    wait_done(100, seen, st, exp);
    total++; if (!seen || st !== exp) begin bad++; $display("[TB] FAIL arst_rerun_status: seen=%b got=%0d want=%0d", seen, st, exp); end
    exp_status_q.push_back(2'd0);
    exp_data_q.push_back(16'h0077);
    read_result(seen, got);
    wd = exp_data_q.pop_front();
    total++; if (!seen || got !== wd) begin bad++; $display("[TB] FAIL arst_rerun_data: seen=%b got=%h want=%h", seen, got, wd); end
    wait_done(50, seen, st, exp);
  endtask

  initial begin
    test_reset();
    test_no_modulus();
    test_compute();
    test_timeout();
    test_bad_cmd_and_ignore();
    test_soft_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] time limit");
  end

endmodule
